// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a power-of-two-deep FIFO between the fetcher and
// the decoder. It owns the fetch PC, tags each accepted word with its PC and
// presents the head entry through a valid/ready handshake. Full/empty are
// exact because an occupancy counter runs beside the wrapping pointers.
module instr_fetch_queue #(
  parameter int DEPTH_LOG2  = 3,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int PC_STEP     = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_from_rob,
  input  logic [PC_WIDTH-1:0]    pc_from_rob,
  input  logic                   stall_from_rob,
  input  logic                   valid_from_fetcher,
  input  logic [INSTR_WIDTH-1:0] instr_from_fetcher,
  output logic [PC_WIDTH-1:0]    pc_to_fetcher,
  output logic                   req_to_fetcher,
  input  logic                   ready_from_decoder,
  output logic                   valid_to_decoder,
  output logic [INSTR_WIDTH-1:0] instr_to_decoder,
  output logic [PC_WIDTH-1:0]    pc_to_decoder,
  output logic [DEPTH_LOG2:0]    count_out,
  output logic                   full_out,
  output logic                   empty_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [PC_WIDTH-1:0]   PC_INIT    = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0]   PC_INC     = PC_WIDTH'(PC_STEP);

  logic [INSTR_WIDTH-1:0] r_instrMem [DEPTH];
  logic [PC_WIDTH-1:0]    r_pcMem    [DEPTH];

  logic [DEPTH_LOG2-1:0]  r_headPtr;
  logic [DEPTH_LOG2-1:0]  r_tailPtr;
  logic [DEPTH_LOG2:0]    r_count;
  logic [PC_WIDTH-1:0]    r_tailPc;

  logic w_full;
  logic w_empty;
  logic w_valid;
  logic w_enq;
  logic w_deq;

  // Handshake qualifiers; full is taken from the current count so a
  // same-cycle dequeue never lets a full queue accept a new word.
  always_comb begin
    w_full  = (r_count == COUNT_FULL);
    w_empty = (r_count == '0);
    w_valid = !w_empty && !stall_from_rob && !flush_from_rob;
    w_enq   = valid_from_fetcher && !w_full && !flush_from_rob;
    w_deq   = w_valid && ready_from_decoder;
  end

  // Pointer, occupancy and fetch-PC state; reset beats flush, flush beats
  // any handshake, and a dropped word leaves the fetch PC so it is re-fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
      r_tailPc  <= PC_INIT;
    end else if (flush_from_rob) begin
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
      r_tailPc  <= pc_from_rob;
    end else begin
      if (w_enq) begin
        r_tailPtr <= r_tailPtr + PTR_ONE;
        r_tailPc  <= r_tailPc + PC_INC;
      end
      if (w_deq) begin
        r_headPtr <= r_headPtr + PTR_ONE;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + COUNT_ONE;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - COUNT_ONE;
      end
    end
  end

  // Entry storage; contents are never cleared, only overwritten on enqueue.
  always_ff @(posedge clk) begin
    if (w_enq && !rst) begin
      r_instrMem[r_tailPtr] <= instr_from_fetcher;
      r_pcMem[r_tailPtr]    <= r_tailPc;
    end
  end

  assign pc_to_fetcher    = r_tailPc;
  assign req_to_fetcher   = !w_full;
  assign valid_to_decoder = w_valid;
  assign instr_to_decoder = r_instrMem[r_headPtr];
  assign pc_to_decoder    = r_pcMem[r_headPtr];
  assign count_out        = r_count;
  assign full_out         = w_full;
  assign empty_out        = w_empty;

endmodule
